// File: rtl/csum_patch_pkg.sv
// Shared types and helpers for the checksum-patching stream stage.
package csum_patch_pkg;

    localparam int unsigned LAST_BIT = 0;
    localparam int unsigned CSUM_W   = 16;

    typedef enum logic [1:0] {
        HEAD,
        PATCH,
        TAIL
    } pos_e;

    function automatic logic [CSUM_W-1:0] bswap16(input logic [CSUM_W-1:0] v);
        return {v[7:0], v[15:8]};
    endfunction

endpackage

// File: rtl/csum_fifo_fwft.sv
// First-word-fall-through FIFO with registered ready, occupancy level and full/empty flags.
module csum_fifo_fwft
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 64,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             rdy_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      level_o
);

    localparam logic [AW:0] FullLvl = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      level_q, level_d;
    logic             rdy_q;
    logic             push_ok, pop_ok;

    assign full_o  = (level_q == FullLvl);
    assign empty_o = (level_q == '0);
    assign rdy_o   = rdy_q;
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Pushes are gated by the registered ready, so a push while full is dropped even on a pop.
    assign push_ok = push_i && rdy_q;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        level_d = level_q;
        if (push_ok && !pop_ok) begin
            level_d = level_q + (AW + 1)'(1);
        end else if (!push_ok && pop_ok) begin
            level_d = level_q - (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            rdy_q    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q <= level_d;
            rdy_q   <= (level_d != FullLvl);
        end
    end

endmodule

// File: rtl/csum_patch_stream.sv
// Overwrites a 16-bit field of word CSUM_WORD in every packet with the next queued checksum.
// Define CSUM_STALL_EN to stall the patch word until a checksum is queued instead of passing it.
module csum_patch_stream
    import csum_patch_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 73,
    parameter int unsigned CSUM_WORD  = 6,
    parameter int unsigned CSUM_LSB   = 25,
    parameter int unsigned CSUM_DEPTH = 64,
    localparam int unsigned LVL_W     = $clog2(CSUM_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CSUM_W-1:0]     csum_data,
    input  logic                  csum_valid,
    output logic                  csum_rdy,
    input  logic [DATA_WIDTH-1:0] input_din,
    input  logic                  input_valid,
    output logic                  input_rdy,
    output logic [DATA_WIDTH-1:0] output_dout,
    output logic                  output_valid,
    input  logic                  output_rdy,
    output logic [LVL_W-1:0]      csum_level,
    output logic                  csum_ovf,
    output logic [15:0]           miss_cnt
);

    // Wide enough to hold the saturation value CSUM_WORD+1.
    localparam int unsigned CNT_W = $clog2(CSUM_WORD + 2);
    localparam logic [CNT_W-1:0] PatchIdx = CNT_W'(CSUM_WORD);
    localparam logic [CNT_W-1:0] CntMax   = CNT_W'(CSUM_WORD + 1);

    logic [CSUM_W-1:0]     fifo_head;
    logic                  fifo_full, fifo_empty, fifo_pop;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    pos_e                  state_q, state_d;
    logic [1:0]            occ_q, occ_d;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
    logic [DATA_WIDTH-1:0] patched;
    logic [15:0]           miss_q, miss_d;
    logic                  ovf_q, active_q;
    logic                  in_acc, out_acc, in_last, patch_word, csum_avail, stall, miss_inc;

    csum_fifo_fwft #(
        .WIDTH (CSUM_W),
        .DEPTH (CSUM_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (csum_valid),
        .wdata_i (bswap16(csum_data)),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .rdy_o   (csum_rdy),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (csum_level)
    );

    assign in_acc     = input_valid && input_rdy;
    assign out_acc    = output_valid && output_rdy;
    assign in_last    = input_din[LAST_BIT];
    assign csum_avail = !fifo_empty;
    assign patch_word = (state_q == PATCH) || ((state_q == HEAD) && (cnt_q == PatchIdx));

`ifdef CSUM_STALL_EN
    assign stall = patch_word && !csum_avail;
`else
    assign stall = 1'b0;
`endif

    assign input_rdy    = active_q && (occ_q != 2'd2) && !stall;
    assign fifo_pop     = in_acc && patch_word && csum_avail;
    assign output_valid = (occ_q != 2'd0);
    assign output_dout  = buf0_q;
    assign csum_ovf     = ovf_q;
    assign miss_cnt     = miss_q;

    // With stalling enabled the first term can never fire, leaving only short packets.
    assign miss_inc = in_acc && ((patch_word && !csum_avail) ||
                                 (in_last && (state_q == HEAD) && !patch_word));

    always_comb begin
        patched = input_din;
        if (patch_word && csum_avail) begin
            patched[CSUM_LSB +: CSUM_W] = fifo_head;
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        if (in_acc) begin
            if (in_last) begin
                cnt_d   = '0;
                state_d = HEAD;
            end else begin
                if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                case (state_q)
                    HEAD: begin
                        if (patch_word) begin
                            state_d = TAIL;
                        end else if (cnt_q + CNT_W'(1) == PatchIdx) begin
                            state_d = PATCH;
                        end
                    end
                    PATCH:   state_d = TAIL;
                    TAIL:    state_d = TAIL;
                    default: state_d = HEAD;
                endcase
            end
        end
    end

    // Two-entry buffer: buf0 is the presented word, buf1 absorbs one word of backpressure.
    always_comb begin
        occ_d  = occ_q;
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        case (occ_q)
            2'd0: begin
                if (in_acc) begin
                    buf0_d = patched;
                    occ_d  = 2'd1;
                end
            end
            2'd1: begin
                if (in_acc && out_acc) begin
                    buf0_d = patched;
                end else if (in_acc) begin
                    buf1_d = patched;
                    occ_d  = 2'd2;
                end else if (out_acc) begin
                    occ_d = 2'd0;
                end
            end
            2'd2: begin
                if (out_acc) begin
                    buf0_d = buf1_q;
                    occ_d  = 2'd1;
                end
            end
            default: occ_d = 2'd0;
        endcase
    end

    always_comb begin
        miss_d = miss_q;
        if (miss_inc && (miss_q != 16'hFFFF)) begin
            miss_d = miss_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            state_q  <= HEAD;
            occ_q    <= 2'd0;
            buf0_q   <= '0;
            buf1_q   <= '0;
            miss_q   <= '0;
            ovf_q    <= 1'b0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            occ_q    <= occ_d;
            buf0_q   <= buf0_d;
            buf1_q   <= buf1_d;
            miss_q   <= miss_d;
            ovf_q    <= ovf_q || (csum_valid && fifo_full);
            active_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_csum_patch_stream.sv
// Scoreboard bench for csum_patch_stream: a behavioural model queues expected words at input accept.
module tb_csum_patch_stream;

    localparam int DW    = 73;
    localparam int DEPTH = 64;
    localparam int PW    = 6;
    localparam int LSB   = 25;

    typedef struct {
        logic [DW-1:0] w;
        bit            patched;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [15:0]   csum_data = '0;
    logic          csum_valid = 1'b0;
    logic          csum_rdy;
    logic [DW-1:0] input_din = '0;
    logic          input_valid = 1'b0;
    logic          input_rdy;
    logic [DW-1:0] output_dout;
    logic          output_valid;
    logic          output_rdy = 1'b1;
    logic [6:0]    csum_level;
    logic          csum_ovf;
    logic [15:0]   miss_cnt;

    exp_t        exp_q[$];
    logic [15:0] mq[$];
    logic [15:0] fields_q[$];
    exp_t        mon_e;
    int          m_cnt = 0;
    int          miss_exp = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          run = 0;
    int          max_run = 0;
    int          total_wait = 0;
    bit          ovf_exp = 0;
    bit          rnd_en = 0;

    csum_patch_stream #(
        .DATA_WIDTH (DW),
        .CSUM_WORD  (PW),
        .CSUM_LSB   (LSB),
        .CSUM_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .csum_data    (csum_data),
        .csum_valid   (csum_valid),
        .csum_rdy     (csum_rdy),
        .input_din    (input_din),
        .input_valid  (input_valid),
        .input_rdy    (input_rdy),
        .output_dout  (output_dout),
        .output_valid (output_valid),
        .output_rdy   (output_rdy),
        .csum_level   (csum_level),
        .csum_ovf     (csum_ovf),
        .miss_cnt     (miss_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        output_rdy = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && output_valid && output_rdy) begin
            run++;
            if (run > max_run) max_run = run;
            if (exp_q.size() == 0) begin
                check_eq("out_unexpected", output_valid, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("dout", output_dout, mon_e.w);
                if (mon_e.patched) fields_q.push_back(output_dout[LSB +: 16]);
            end
        end else begin
            run = 0;
        end
    end

    task automatic model_accept(input logic [DW-1:0] w);
        exp_t e;
        e.w = w;
        e.patched = 0;
        if (m_cnt == PW) begin
            if (mq.size() > 0) begin
                e.w[LSB +: 16] = mq.pop_front();
                e.patched = 1;
            end else begin
                miss_exp++;
            end
        end
        if (w[0]) begin
            if (m_cnt < PW) miss_exp++;
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
        exp_q.push_back(e);
    endtask

    task automatic send_word(input logic [DW-1:0] w);
        int waits = 0;
        bit ok = 0;
        input_din = w;
        input_valid = 1'b1;
        while (!ok) begin
            @(negedge clk);
            if (input_rdy) begin
                ok = 1;
            end else begin
                waits++;
                if (waits > 300) begin
                    check_eq("input_timeout", input_rdy, 1'b1);
                    input_valid = 1'b0;
                    return;
                end
            end
        end
        @(posedge clk);
        #1;
        total_wait += waits;
        model_accept(w);
    endtask

    task automatic send_pkt(input int n);
        logic [95:0]   r;
        logic [DW-1:0] w;
        for (int i = 0; i < n; i++) begin
            r = {$urandom(), $urandom(), $urandom()};
            w = r[DW-1:0];
            w[0] = (i == n - 1);
            send_word(w);
        end
    endtask

    task automatic push_csum(input logic [15:0] v);
        csum_data = v;
        csum_valid = 1'b1;
        @(posedge clk);
        #1;
        csum_valid = 1'b0;
        if (mq.size() < DEPTH) mq.push_back({v[7:0], v[15:8]});
        else ovf_exp = 1;
    endtask

    task automatic drain();
        int t = 0;
        input_valid = 1'b0;
        while (exp_q.size() > 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        check_eq("drain", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_field(input string tag, input logic [15:0] exp);
        check_eq({tag, "_present"}, fields_q.size() > 0, 1'b1);
        if (fields_q.size() > 0) check_eq(tag, fields_q.pop_front(), exp);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_rel_input_rdy", input_rdy, 1'b1);
        check_eq("rst_rel_csum_rdy", csum_rdy, 1'b1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_output_valid", output_valid, 1'b0);
        check_eq("rst_output_dout", output_dout, '0);
        check_eq("rst_input_rdy", input_rdy, 1'b0);
        check_eq("rst_csum_rdy", csum_rdy, 1'b0);
        check_eq("rst_csum_level", csum_level, 0);
        check_eq("rst_csum_ovf", csum_ovf, 1'b0);
        check_eq("rst_miss_cnt", miss_cnt, 0);
        release_reset();

        // Single 10-word packet with one pre-queued checksum.
        push_csum(16'h1234);
        @(posedge clk);
        #1;
        check_eq("t1_level_before", csum_level, 1);
        send_pkt(10);
        drain();
        check_field("t1_field", 16'h3412);
        check_eq("t1_level_after", csum_level, 0);
        check_eq("t1_miss", miss_cnt, 0);

        // Three back-to-back packets at full rate.
        push_csum(16'hAAAA);
        push_csum(16'hBBBB);
        push_csum(16'hCCCC);
        @(posedge clk);
        #1;
        max_run = 0;
        total_wait = 0;
        send_pkt(8);
        send_pkt(8);
        send_pkt(8);
        drain();
        check_eq("t2_in_stalls", total_wait, 0);
        check_eq("t2_out_run", max_run, 24);
        check_field("t2_field0", 16'hAAAA);
        check_field("t2_field1", 16'hBBBB);
        check_field("t2_field2", 16'hCCCC);

        // Short packet keeps its checksum for the next packet.
        push_csum(16'h5AC3);
        send_pkt(4);
        drain();
        check_eq("t3_level_kept", csum_level, 1);
        check_eq("t3_miss", miss_cnt, 1);
        check_eq("t3_miss_model", miss_cnt, miss_exp);
        check_eq("t3_no_field", fields_q.size(), 0);
        send_pkt(8);
        drain();
        check_field("t3_field", 16'hC35A);
        check_eq("t3_level_after", csum_level, 0);

`ifdef CSUM_STALL_EN
        // Patch word waits for a checksum pushed well after it arrives.
        total_wait = 0;
        fork
            send_pkt(8);
            begin
                repeat (11) @(posedge clk);
                #1;
                push_csum(16'h00FF);
            end
        join
        drain();
        check_eq("t4_stall_cycles", total_wait, 6);
        check_field("t4_field", 16'hFF00);
        check_eq("t4_miss", miss_cnt, 1);
`else
        // Patch word with an empty FIFO passes unmodified and counts a miss.
        send_pkt(8);
        drain();
        check_eq("t4_no_field", fields_q.size(), 0);
        check_eq("t4_miss", miss_cnt, 2);
`endif
        check_eq("t4_miss_model", miss_cnt, miss_exp);
        check_eq("t4_level", csum_level, 0);

        // Overflow: 65 pushes into a 64-deep FIFO.
        for (int i = 0; i < DEPTH; i++) push_csum(16'(i + 16'h100));
        check_eq("t5_rdy_full", csum_rdy, 1'b0);
        check_eq("t5_ovf_before", csum_ovf, 1'b0);
        push_csum(16'hDEAD);
        check_eq("t5_ovf", csum_ovf, ovf_exp);
        check_eq("t5_level", csum_level, DEPTH);
        repeat (5) @(posedge clk);
        #1;
        check_eq("t5_ovf_sticky", csum_ovf, 1'b1);
        check_eq("t5_level_hold", csum_level, DEPTH);

        // Random backpressure, then reset in the middle of a packet.
        rst_n = 1'b0;
        exp_q.delete();
        mq.delete();
        m_cnt = 0;
        #2;
        check_eq("t6_rst1_ovf", csum_ovf, 1'b0);
        release_reset();
        for (int i = 0; i < 4; i++) push_csum(16'(16'h7100 + i));
        rnd_en = 1;
        send_pkt(8);
        send_pkt(8);
        send_pkt(PW - 3);
        check_eq("t6_inflight", exp_q.size() <= 2, 1'b1);
        input_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_output_valid", output_valid, 1'b0);
        check_eq("t6_rst_level", csum_level, 0);
        check_eq("t6_rst_input_rdy", input_rdy, 1'b0);
        exp_q.delete();
        mq.delete();
        fields_q.delete();
        m_cnt = 0;
        rnd_en = 0;
        repeat (2) @(posedge clk);
        release_reset();
        check_eq("t6_miss_cleared", miss_cnt, 0);
        push_csum(16'hBEEF);
        send_pkt(10);
        drain();
        check_field("t6_field", 16'hEFBE);
        check_eq("t6_level_after", csum_level, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
